// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with an IF/ID register, a one-entry hold buffer and squash of redirected reads
// A read is always outstanding outside HOLD; SQUASH keeps the old address on the bus until its response is dropped.
module fetch_stage #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_target,
   output logic        imem_read,
   output logic [15:0] imem_address,
   input  logic [15:0] imem_rdata,
   input  logic        imem_resp,
   output logic        ifid_valid,
   output logic [15:0] ifid_ir,
   output logic [15:0] ifid_pc,
   output logic [3:0]  opcode,
   output logic        ir4,
   output logic        ir5,
   output logic        ir11
);

   typedef enum logic [1:0] {S_REQ, S_HOLD, S_SQUASH} state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] sq_pc_q, sq_pc_d;
   logic [15:0] hold_ir_q, hold_ir_d;
   logic [15:0] hold_pc_q, hold_pc_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [15:0] ifid_ir_q, ifid_ir_d;
   logic [15:0] ifid_pc_q, ifid_pc_d;
   logic [15:0] pc_inc;
   logic [15:0] tgt;

   assign pc_inc = pc_q + 16'd2;
   assign tgt    = redirect_target & 16'hFFFE;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      sq_pc_d      = sq_pc_q;
      hold_ir_d    = hold_ir_q;
      hold_pc_d    = hold_pc_q;
      ifid_valid_d = ifid_valid_q;
      ifid_ir_d    = ifid_ir_q;
      ifid_pc_d    = ifid_pc_q;
      // An invalid IF/ID entry always reads as a zero (no-op) word and zero PC.
      if (redirect || (!stall && !(state_q == S_HOLD))) begin
         ifid_valid_d = 1'b0;
         ifid_ir_d    = 16'h0000;
         ifid_pc_d    = 16'h0000;
      end
      case (state_q)
         S_REQ: begin
            if (redirect) begin
               if (imem_resp) begin
                  pc_d = tgt;
               end else begin
                  sq_pc_d = tgt;
                  state_d = S_SQUASH;
               end
            end else if (imem_resp) begin
               pc_d = pc_inc;
               if (stall) begin
                  hold_ir_d = imem_rdata;
                  hold_pc_d = pc_inc;
                  state_d   = S_HOLD;
               end else begin
                  ifid_valid_d = 1'b1;
                  ifid_ir_d    = imem_rdata;
                  ifid_pc_d    = pc_inc;
               end
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_d      = tgt;
               hold_ir_d = 16'h0000;
               hold_pc_d = 16'h0000;
               state_d   = S_REQ;
            end else if (!stall) begin
               ifid_valid_d = 1'b1;
               ifid_ir_d    = hold_ir_q;
               ifid_pc_d    = hold_pc_q;
               hold_ir_d    = 16'h0000;
               hold_pc_d    = 16'h0000;
               state_d      = S_REQ;
            end
         end
         S_SQUASH: begin
            // The latest redirect wins; the outstanding word is never used.
            if (imem_resp) begin
               pc_d    = redirect ? tgt : sq_pc_q;
               state_d = S_REQ;
            end else if (redirect) begin
               sq_pc_d = tgt;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         sq_pc_q      <= RESET_PC;
         hold_ir_q    <= 16'h0000;
         hold_pc_q    <= 16'h0000;
         ifid_valid_q <= 1'b0;
         ifid_ir_q    <= 16'h0000;
         ifid_pc_q    <= 16'h0000;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         sq_pc_q      <= sq_pc_d;
         hold_ir_q    <= hold_ir_d;
         hold_pc_q    <= hold_pc_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_ir_q    <= ifid_ir_d;
         ifid_pc_q    <= ifid_pc_d;
      end
   end

   // Read request is held low during reset and decoded from state otherwise.
   assign imem_read    = rst_n && (state_q != S_HOLD);
   assign imem_address = pc_q;
   assign ifid_valid   = ifid_valid_q;
   assign ifid_ir      = ifid_ir_q;
   assign ifid_pc      = ifid_pc_q;
   assign opcode       = ifid_ir_q[15:12];
   assign ir4          = ifid_ir_q[4];
   assign ir5          = ifid_ir_q[5];
   assign ir11         = ifid_ir_q[11];

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed scenarios plus randomized run scored against an in-order fetch stream model
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_target;
   logic        imem_read;
   logic [15:0] imem_address;
   logic [15:0] imem_rdata;
   logic        imem_resp;
   logic        ifid_valid;
   logic [15:0] ifid_ir;
   logic [15:0] ifid_pc;
   logic [3:0]  opcode;
   logic        ir4, ir5, ir11;

   int checks   = 0;
   int failures = 0;

   fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
      .redirect_target(redirect_target), .imem_read(imem_read),
      .imem_address(imem_address), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
      .ifid_valid(ifid_valid), .ifid_ir(ifid_ir), .ifid_pc(ifid_pc),
      .opcode(opcode), .ir4(ir4), .ir5(ir5), .ir11(ir11)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return (a * 16'h9E37) ^ 16'h5A3C;
   endfunction

   task automatic drive(input logic s, input logic r, input logic [15:0] t,
                        input logic rs, input logic [15:0] d);
      stall = s; redirect = r; redirect_target = t; imem_resp = rs; imem_rdata = d;
      @(negedge clk);
   endtask

   initial begin
      logic [15:0] exp_pc;
      logic [15:0] prev_addr;
      logic [15:0] w;
      bit          prev_out;
      bit          exp_inval;
      int          consumed;
      rst_n = 1'b0; stall = 0; redirect = 0; redirect_target = 0; imem_resp = 0; imem_rdata = 0;
      @(negedge clk);
      check("rst_read", imem_read, 0);
      check("rst_valid", ifid_valid, 0);
      check("rst_ir", ifid_ir, 0);
      check("rst_pc", ifid_pc, 0);
      rst_n = 1'b1;
      #1;
      check("rel_read", imem_read, 1);
      check("rel_addr", imem_address, 16'h0000);

      // back-to-back fetches
      drive(0, 0, 0, 1, 16'h1234);
      check("f1_ir", ifid_ir, 16'h1234);
      check("f1_pc", ifid_pc, 16'h0002);
      check("f1_op", opcode, 4'h1);
      check("f1_valid", ifid_valid, 1);
      drive(0, 0, 0, 1, 16'h5678);
      check("f2_ir", ifid_ir, 16'h5678);
      check("f2_pc", ifid_pc, 16'h0004);
      check("f2_addr", imem_address, 16'h0004);

      // stall parks the word in the hold buffer
      drive(1, 0, 0, 1, 16'hABCD);
      check("h1_read", imem_read, 0);
      check("h1_ir", ifid_ir, 16'h5678);
      drive(1, 0, 0, 0, 16'h0000);
      drive(1, 0, 0, 0, 16'h0000);
      check("h3_read", imem_read, 0);
      check("h3_pc", ifid_pc, 16'h0004);
      drive(0, 0, 0, 0, 16'h0000);
      check("h4_ir", ifid_ir, 16'hABCD);
      check("h4_pc", ifid_pc, 16'h0006);
      check("h4_ir11", ir11, 1);
      check("h4_ir45", {ir5, ir4}, 2'b00);
      check("h4_read", imem_read, 1);
      check("h4_addr", imem_address, 16'h0006);

      // redirect while read outstanding, response two cycles late
      drive(0, 1, 16'h0040, 0, 16'h0000);
      check("sq_valid", ifid_valid, 0);
      check("sq_addr", imem_address, 16'h0006);
      drive(0, 0, 0, 0, 16'h0000);
      check("sq_read", imem_read, 1);
      drive(0, 0, 0, 1, 16'hDEAD);
      check("sq_drop", ifid_valid, 0);
      check("sq_newaddr", imem_address, 16'h0040);

      // redirect with stall while in HOLD
      drive(1, 0, 0, 1, 16'h1111);
      check("rh_read", imem_read, 0);
      drive(1, 1, 16'h0081, 0, 16'h0000);
      check("rh_valid", ifid_valid, 0);
      check("rh_addr", imem_address, 16'h0080);
      drive(0, 0, 0, 1, 16'h2222);
      check("rh_ir", ifid_ir, 16'h2222);
      check("rh_pc", ifid_pc, 16'h0082);

      // PC wrap
      drive(0, 1, 16'hFFFE, 1, 16'h9999);
      check("wr_valid", ifid_valid, 0);
      check("wr_addr", imem_address, 16'hFFFE);
      drive(0, 0, 0, 1, 16'h3333);
      check("wr_pc", ifid_pc, 16'h0000);
      check("wr_ir", ifid_ir, 16'h3333);
      check("wr_addr2", imem_address, 16'h0000);

      // reset mid-HOLD
      drive(1, 0, 0, 1, 16'h4444);
      check("rm_read", imem_read, 0);
      stall = 0; imem_resp = 0;
      rst_n = 1'b0;
      #1;
      check("rm_read0", imem_read, 0);
      check("rm_valid", ifid_valid, 0);
      check("rm_ir", ifid_ir, 0);
      check("rm_addr", imem_address, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rm_reread", imem_read, 1);
      check("rm_readdr", imem_address, 16'h0000);

      // randomized run against an in-order stream model
      exp_pc = 16'h0002; prev_out = 0; prev_addr = 0; exp_inval = 0; consumed = 0;
      for (int i = 0; i < 3000; i++) begin
         if (prev_out) begin
            check("rnd_rd_kept", imem_read, 1);
            check("rnd_addr_kept", imem_address, prev_addr);
         end
         if (exp_inval) check("rnd_redir_inval", ifid_valid, 0);
         if (!ifid_valid) begin
            check("rnd_inval_ir", ifid_ir, 0);
            check("rnd_inval_pc", ifid_pc, 0);
         end
         stall           = ($urandom_range(0, 9) < 3);
         redirect        = ($urandom_range(0, 99) < 8);
         redirect_target = 16'($urandom);
         imem_resp       = imem_read && ($urandom_range(0, 9) < 6);
         imem_rdata      = imem_resp ? mem_word(imem_address) : 16'($urandom);
         if (ifid_valid && !stall && !redirect) begin
            w = mem_word(exp_pc - 16'd2);
            check("rnd_pc", ifid_pc, exp_pc);
            check("rnd_ir", ifid_ir, w);
            check("rnd_op", opcode, w[15:12]);
            exp_pc = exp_pc + 16'd2;
            consumed++;
         end
         prev_out  = imem_read && !imem_resp;
         prev_addr = imem_address;
         exp_inval = redirect;
         if (redirect) exp_pc = {redirect_target[15:1], 1'b0} + 16'd2;
         @(negedge clk);
      end
      check("rnd_progress", 16'(consumed > 300), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC loaded on reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port stall  input  1  decode cannot accept a new IF/ID entry this cycle.
REQ-005 SHALL have port redirect  input  1  taken branch, jump or trap from a later stage.
REQ-006 SHALL have port redirect_target  input  16  new PC when redirect=1.
REQ-007 SHALL have port imem_read  output  1  instruction read request.
REQ-008 SHALL have port imem_address  output  16  read address, always the internal PC.
REQ-009 SHALL have port imem_rdata  input  16  instruction word, valid when imem_resp=1.
REQ-010 SHALL have port imem_resp  input  1  single-cycle read completion.
REQ-011 SHALL have port ifid_valid  output  1  IF/ID entry holds a real instruction.
REQ-012 SHALL have port ifid_ir  output  16  registered instruction word.
REQ-013 SHALL have port ifid_pc  output  16  PC+2 of the registered instruction.
REQ-014 SHALL have port opcode  output  4  ifid_ir[15:12], lc3b_opcode, for the control ROM.
REQ-015 SHALL have ports ir4, ir5, ir11  output  1 each  ifid_ir bits 4, 5 and 11.

Function
REQ-016 SHALL implement a 3-state FSM: REQ (read outstanding), HOLD (fetched word parked, stall active), SQUASH (read outstanding, result to be discarded).
REQ-017 In REQ and SQUASH, imem_read SHALL be 1; in HOLD it SHALL be 0; imem_read SHALL never drop while a read is outstanding without imem_resp.
REQ-018 In REQ with imem_resp=1, stall=0, redirect=0: the IF/ID register SHALL take ifid_ir=imem_rdata, ifid_pc=PC+2, ifid_valid=1 at the next edge; PC SHALL become PC+2; state stays REQ.
REQ-019 In REQ with imem_resp=1, stall=1, redirect=0: the word and PC+2 SHALL be captured into a one-entry hold buffer; PC SHALL become PC+2; state SHALL go to HOLD; IF/ID SHALL be unchanged.
REQ-020 In HOLD with stall=0, redirect=0: the hold buffer SHALL move into IF/ID with ifid_valid=1; state SHALL go to REQ.
REQ-021 With stall=1 and no redirect, IF/ID SHALL hold its value in every state.
REQ-022 Any state with redirect=1: PC SHALL become redirect_target; ifid_valid SHALL clear to 0; the hold buffer SHALL be discarded. redirect SHALL take precedence over stall.
REQ-023 Redirect in REQ without imem_resp SHALL go to SQUASH. Redirect in REQ with imem_resp, or in HOLD, SHALL go to REQ.
REQ-024 In SQUASH, imem_address SHALL still show the old PC until imem_resp. On imem_resp the data SHALL be dropped and state SHALL go to REQ at the new PC. A further redirect in SQUASH SHALL only update PC.
REQ-025 When ifid_valid=0, ifid_ir SHALL read 16'h0000 (BR with nzp=000, a no-op) and ifid_pc SHALL read 16'h0000.
REQ-026 PC arithmetic SHALL be 16-bit modulo: 16'hFFFE+2 = 16'h0000. Bit 0 of redirect_target SHALL be forced to 0.
REQ-027 Instruction order SHALL be preserved; no fetched word is lost or duplicated unless squashed by redirect.
REQ-028 Best-case throughput SHALL be one instruction per cycle. Latency from imem_resp to ifid_valid SHALL be 1 edge.

Reset
REQ-029 While rst_n=0, asynchronously: PC=RESET_PC, state=REQ, ifid_valid=0, ifid_ir=0, ifid_pc=0, hold buffer empty.
REQ-030 imem_read SHALL be 0 while rst_n=0. It SHALL assert with imem_address=RESET_PC in the first cycle after rst_n rises.
REQ-031 Reset asserted mid-read SHALL abandon the read with no squash tracking; memory is reset by the same rst_n.

Verification
REQ-032 Reset release, imem_resp every cycle with data 16'h1234, 16'h5678 -> ifid_ir 1234/ifid_pc 0002, then 5678/0004 on consecutive cycles; opcode=4'h1 first.
REQ-033 stall=1 for 3 cycles while resp returns 16'hABCD -> state HOLD, imem_read=0, IF/ID unchanged; stall=0 -> ifid_ir=ABCD, valid=1 next edge, read resumes at PC+2.
REQ-034 redirect=1, target 16'h0040, asserted while a read is outstanding with resp delayed 2 cycles -> returned word dropped, ifid_valid=0, next imem_address=0040.
REQ-035 redirect and stall in the same cycle during HOLD -> hold buffer flushed, ifid_valid=0, next read at target.
REQ-036 PC=16'hFFFE fetch accepted -> ifid_pc=16'h0000, next imem_address=16'h0000.
REQ-037 rst_n low for one cycle mid-HOLD -> all outputs at reset values immediately; refetch from RESET_PC.
